prog_timer: RTL
===============

# prog_timer

Parametrised successor to the fixed 0-to-10 one-second counter: a programmable-modulus timer with a built-in prescaler, run-time limit, up/down direction, synchronous load and a terminal-count pulse. It sits between the 50 MHz system clock domain and display/control logic, replacing per-project hard-coded counters. Multiple instances cascade by feeding one instance's `Tc` into the next instance's `En`.

## Interface
- `WIDTH`, 4: width of the count `Q`, `Limit` and `LoadVal`.
- `PRESCALE`, 50_000_000: enabled clocks per count step. Must be ≥1; 1 means step on every enabled clock.
- `Clock` input 1: system clock, 50 MHz.
- `Clr` input 1: reset, asynchronous, active-high.
- `En` input 1: count enable; gates both the prescaler and the counter.
- `Load` input 1: synchronous load strobe.
- `LoadVal` input WIDTH: value to load.
- `Limit` input WIDTH: terminal count. Sampled every cycle, so it may change at run time.
- `Down` input 1: 0 counts up, 1 counts down.
- `OneShot` input 1: one-shot mode select. Only honoured when `TIMER_ONESHOT_EN` is defined.
- `Q` output WIDTH: current count.
- `Tick` output 1: prescaler strobe.
- `Tc` output 1: terminal-count pulse, one cycle wide.
- `Done` output 1: one-shot completion flag.

## Operation
- Internal prescaler count `P` runs from 0 to PRESCALE-1; its width is `$clog2(PRESCALE)`, minimum 1 bit.
- Step event: `En`=1 and `P`==PRESCALE-1 and `Done`=0.
- Priority on each edge, highest first:
  - `Clr`
  - `Load`: `Q` takes `LoadVal`, clamped to `Limit` if `LoadVal` > `Limit`. `P` goes to 0. `Done` clears.
  - Step event.
  - `En`=1 with no step: `P` increments.
  - Otherwise: hold.
- Step in up mode:
  - If `Q` ≥ `Limit`: `Q` goes to 0 and a terminal event occurs.
  - Else `Q` goes to `Q`+1.
- Step in down mode:
  - If `Q` == 0: `Q` goes to `Limit` and a terminal event occurs.
  - Else if `Q` > `Limit`: `Q` goes to `Limit`, with no terminal event.
  - Else `Q` goes to `Q`-1.
- `Limit`=0: `Q` stays 0 and every step is a terminal event.
- `Down` may toggle at any time; it takes effect on the next step.
- All arithmetic is unsigned WIDTH-bit. There is no modular overflow beyond the `Limit` rules above.

## Timing
- Reset values: `Q`=0, `P`=0, `Tc`=0, `Done`=0. `Tick`=0 because it is derived from `P`=0.
- `Tick` is combinational: high in the cycle where a step event is true.
- `Q` updates on the edge that ends a `Tick` cycle.
- `Tc` is registered: high for exactly one cycle, the cycle after the terminal-event edge, aligned with the new `Q`.
- Step period: PRESCALE enabled clocks. Dropping `En` freezes `P` and `Q`; raising it resumes with no lost or extra counts.
- `Load` and a step event in the same cycle: `Load` wins, and no `Tc` is produced.
- `Clr` asserted mid-count: all state returns to reset values immediately, without waiting for a clock edge.

## Configuration
- Macro: `TIMER_ONESHOT_EN`.
- When defined and `OneShot`=1, a terminal event does not wrap:
  - Up mode: `Q` holds at `Limit`.
  - Down mode: `Q` holds at 0.
  - `Tc` still pulses once.
  - `Done` is set on the same edge and stays high until `Load` or `Clr`.
  - While `Done`=1, `P` and `Q` freeze and `Tick` stays 0.
- When not defined: the `OneShot` port is present but ignored, `Done` is tied to 0, and the timer always wraps.

## Structure
- Package `timer_pkg`:
  - `CLOCK_HZ` = 50_000_000.
  - `PRESCALE_1S` = `CLOCK_HZ`.
  - `PRESCALE_1MS` = `CLOCK_HZ`/1000.
  - Typedef `count_dir_t` with values `CNT_UP` and `CNT_DOWN`.
- Sub-module `tick_gen`:
  - Owns `P` and the `Tick` output.
  - Inputs: `Clock`, `Clr`, `En`, `Hold` (driven by `Done`), `Restart` (driven by `Load`).
  - Parameter: `PRESCALE`.

## Test plan
All scenarios use PRESCALE=4 and WIDTH=4 unless stated.
- Pulse `Clr` high mid-count -> `Q`=0, `Tc`=0 and `Done`=0 before the next edge.
- Up mode, `Limit`=10, `En`=1 for 48 clocks:
  - `Q` steps 0..10 then 0, once every 4 clocks.
  - `Tc` is high only in the cycle where `Q` returns to 0.
- Down mode, `Limit`=5, `Load` with `LoadVal`=9:
  - `Q` loads 5 (clamped).
  - `Q` then counts 4,3,2,1,0,5, with `Tc` high when `Q` becomes 5.
- `En` low for 7 clocks at `P`=2 -> `Q` frozen; the next step occurs 2 clocks after `En` returns high.
- `Load` asserted in a `Tick` cycle with `LoadVal`=3 -> `Q`=3, `P`=0, no `Tc`.
- With `TIMER_ONESHOT_EN` defined, `OneShot`=1, up mode, `Limit`=2:
  - `Q` counts 0,1,2, then `Tc` pulses once.
  - `Done`=1 and `Q` holds at 2 for 20+ clocks.
  - `Load` with `LoadVal`=0 clears `Done`.

Source files
------------

// File: rtl/prog_timer_pkg.sv
// Shared constants and types for the programmable timer.
package timer_pkg;

   localparam int unsigned CLOCK_HZ     = 50_000_000;
   localparam int unsigned PRESCALE_1S  = CLOCK_HZ;
   localparam int unsigned PRESCALE_1MS = CLOCK_HZ / 1000;

   typedef enum logic {
      CNT_UP   = 1'b0,
      CNT_DOWN = 1'b1
   } count_dir_t;

endpackage

// File: rtl/prog_timer_if.sv
// Control/status bundle of prog_timer; master is the controlling logic, slave is the timer.
interface prog_timer_if #(
   parameter int unsigned WIDTH = 4
);
   logic             En;
   logic             Load;
   logic [WIDTH-1:0] LoadVal;
   logic [WIDTH-1:0] Limit;
   logic             Down;
   logic             OneShot;
   logic [WIDTH-1:0] Q;
   logic             Tick;
   logic             Tc;
   logic             Done;

   modport master (
      output En, Load, LoadVal, Limit, Down, OneShot,
      input  Q, Tick, Tc, Done
   );

   modport slave (
      input  En, Load, LoadVal, Limit, Down, OneShot,
      output Q, Tick, Tc, Done
   );
endinterface

// File: rtl/prog_timer_tick_gen.sv
// Prescaler: counts enabled clocks 0..PRESCALE-1 and strobes Tick on the last one.
module tick_gen #(
   parameter int unsigned PRESCALE = 4
) (
   input  logic Clock,
   input  logic Clr,
   input  logic En,
   input  logic Hold,
   input  logic Restart,
   output logic Tick
);
   localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   logic [PW-1:0] p;

   assign Tick = En && !Hold && (p == PMAX);

   always_ff @(posedge Clock or posedge Clr) begin
      if (Clr)
         p <= '0;
      else if (Restart)
         p <= '0;
      else if (En && !Hold)
         p <= (p == PMAX) ? '0 : p + 1'b1;
   end
endmodule

// File: rtl/prog_timer.sv
// Programmable-modulus up/down timer with prescaler, load and terminal-count pulse.
// Optional one-shot mode is compiled in with `define TIMER_ONESHOT_EN.
module prog_timer
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned PRESCALE = PRESCALE_1S
) (
   input logic        Clock,
   input logic        Clr,
   prog_timer_if.slave bus
);
   logic [WIDTH-1:0] q, q_next, load_q;
   logic             tc, term, tick, done, oneshot;
   count_dir_t       dir;

   tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
      .Clock   (Clock),
      .Clr     (Clr),
      .En      (bus.En),
      .Hold    (done),
      .Restart (bus.Load),
      .Tick    (tick)
   );

   assign dir    = bus.Down ? CNT_DOWN : CNT_UP;
   assign load_q = (bus.LoadVal > bus.Limit) ? bus.Limit : bus.LoadVal;

   always_comb begin
      q_next = q;
      term   = 1'b0;
      if (dir == CNT_UP) begin
         if (q >= bus.Limit) begin
            term   = 1'b1;
            q_next = oneshot ? bus.Limit : '0;
         end else begin
            q_next = q + 1'b1;
         end
      end else begin
         // A run-time Limit drop below Q snaps Q down without a terminal event.
         if (q == '0) begin
            term   = 1'b1;
            q_next = oneshot ? '0 : bus.Limit;
         end else if (q > bus.Limit) begin
            q_next = bus.Limit;
         end else begin
            q_next = q - 1'b1;
         end
      end
   end

   always_ff @(posedge Clock or posedge Clr) begin
      if (Clr) begin
         q  <= '0;
         tc <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (bus.Load) begin
            q <= load_q;
         end else if (tick) begin
            q  <= q_next;
            tc <= term;
         end
      end
   end

`ifdef TIMER_ONESHOT_EN
   assign oneshot = bus.OneShot;

   always_ff @(posedge Clock or posedge Clr) begin
      if (Clr)
         done <= 1'b0;
      else if (bus.Load)
         done <= 1'b0;
      else if (tick && term && oneshot)
         done <= 1'b1;
   end
`else
   logic unused_oneshot;
   assign unused_oneshot = bus.OneShot;
   assign oneshot        = 1'b0;
   assign done           = 1'b0;
`endif

   assign bus.Q    = q;
   assign bus.Tick = tick;
   assign bus.Tc   = tc;
   assign bus.Done = done;
endmodule
